// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the memory-mapped data memory: default I/O window
// addresses, the address-region enum and the address decoder.
package dmem_mmio_pkg;

  localparam int LED_BASE_DEF  = 0;
  localparam int SW_BASE_DEF   = 4;
  localparam int EDGE_ADDR_DEF = 8;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_LED,
    REGION_SW,
    REGION_EDGE
  } region_e;

  // Addresses past the populated LED/SW entries fall through to RAM.
  function automatic region_e decode_region(input int a, input int led_base,
                                            input int num_led, input int sw_base,
                                            input int num_sw, input int edge_addr);
    if (a == edge_addr) return REGION_EDGE;
    if (a >= led_base && a < led_base + num_led) return REGION_LED;
    if (a >= sw_base && a < sw_base + num_sw) return REGION_SW;
    return REGION_RAM;
  endfunction

endpackage

// File: rtl/data_memory_mmio_sw_conditioner.sv
// One switch channel: 2-flop synchroniser, optional debounce (SW_DEBOUNCE_EN)
// and a rising-edge pulse aligned with the edge where sw_cond goes high.
module sw_conditioner #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_cond,
  output logic sw_rise
);

  logic sync_p0, sync_p1;

  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be >= 1");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             cond_q;
  logic             settle;

  // settle is true in the last differing cycle, so sw_rise lines up with the
  // clock edge that updates cond_q.
  assign settle = (sync_p1 != cond_q) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      cond_q <= 1'b0;
    end else if (sync_p1 == cond_q) begin
      cnt <= '0;
    end else if (settle) begin
      cond_q <= sync_p1;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sw_cond = cond_q;
  assign sw_rise = settle & sync_p1;
`else
  assign sw_cond = sync_p1;
  assign sw_rise = sync_p0 & ~sync_p1;
`endif

endmodule

// File: rtl/data_memory_mmio.sv
// Single-port data RAM with an LED / switch / switch-edge I/O window and
// registered reads. Define SW_DEBOUNCE_EN to add per-switch debounce.
module data_memory_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 9,
  parameter int NUM_LED      = 2,
  parameter int NUM_SW       = 2,
  parameter int LED_BASE     = LED_BASE_DEF,
  parameter int SW_BASE      = SW_BASE_DEF,
  parameter int EDGE_ADDR    = EDGE_ADDR_DEF,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic [NUM_SW-1:0] sw_in,
  output logic [NUM_LED-1:0] led_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] led_q [NUM_LED];
  logic [NUM_SW-1:0] edge_q, edge_clr, sw_cond, sw_rise;
  logic [DATA_W-1:0] rd_mux, rdata_p1;
  logic              vld_p1, wr_en, rd_en;
  region_e           region;

  if (NUM_SW > DATA_W) begin : g_bad_num_sw
    $error("NUM_SW must not exceed DATA_W");
  end

  assign wr_en  = req & we;
  assign rd_en  = req & ~we;
  assign region = decode_region(int'(addr), LED_BASE, NUM_LED, SW_BASE, NUM_SW, EDGE_ADDR);

  for (genvar j = 0; j < NUM_SW; j++) begin : g_sw
    sw_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_raw (sw_in[j]),
      .sw_cond(sw_cond[j]),
      .sw_rise(sw_rise[j])
    );
  end

  always_ff @(posedge clk) begin
    if (wr_en && region == REGION_RAM) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LED; i++) led_q[i] <= '0;
    end else if (wr_en && region == REGION_LED) begin
      for (int i = 0; i < NUM_LED; i++)
        if (addr == ADDR_W'(LED_BASE + i)) led_q[i] <= wdata;
    end
  end

  // A rising edge in the same cycle as a W1C of that bit keeps the bit set.
  assign edge_clr = (wr_en && region == REGION_EDGE) ? wdata[NUM_SW-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_q <= '0;
    else        edge_q <= (edge_q & ~edge_clr) | sw_rise;
  end

  always_comb begin
    rd_mux = mem[addr];
    case (region)
      REGION_LED: begin
        for (int i = 0; i < NUM_LED; i++)
          if (addr == ADDR_W'(LED_BASE + i)) rd_mux = led_q[i];
      end
      REGION_SW: begin
        rd_mux = '0;
        for (int j = 0; j < NUM_SW; j++)
          if (addr == ADDR_W'(SW_BASE + j)) rd_mux = DATA_W'(sw_cond[j]);
      end
      REGION_EDGE: rd_mux = DATA_W'(edge_q);
      default: ;
    endcase
  end

  // Read result stage: data and valid registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rdata_p1 <= rd_mux;
    end
  end

  assign rdata  = rdata_p1;
  assign rvalid = vld_p1;

  always_comb begin
    led_out = '0;
    for (int i = 0; i < NUM_LED; i++) led_out[i] = led_q[i][0];
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: RAM, LED, switch, edge W1C and reset.
module tb_data_memory_mmio;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int NUM_LED = 2;
  localparam int NUM_SW = 2;
`ifdef SW_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int SW_WAIT   = 2 + DEB;
  localparam int RISE_WAIT = 1 + DEB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [NUM_SW-1:0] sw_in = '0;
  logic [NUM_LED-1:0] led_out;

  int total = 0;
  int bad = 0;

  data_memory_mmio #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_LED(NUM_LED), .NUM_SW(NUM_SW),
    .LED_BASE(0), .SW_BASE(4), .EDGE_ADDR(8), .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .sw_in(sw_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    req = 1'b1; we = 1'b0; addr = a;
    tick();
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (rdata !== 16'h0000 || rvalid !== 1'b0) begin
      bad++; $display("FAIL reset_rd: rdata=%h rvalid=%b want 0000/0", rdata, rvalid);
    end
    total++;
    if (led_out !== 2'b00) begin
      bad++; $display("FAIL reset_led: led_out=%b want 00", led_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(9'd8);
    total++;
    if (rvalid !== 1'b1 || rdata !== 16'h0000) begin
      bad++; $display("FAIL reset_edge: rvalid=%b rdata=%h want 1/0000", rvalid, rdata);
    end
  endtask

  task automatic test_ram();
    wr(9'd100, 16'h1234);
    rd(9'd100);
    total++;
    if (rvalid !== 1'b1 || rdata !== 16'h1234) begin
      bad++; $display("FAIL ram_raw: rvalid=%b rdata=%h want 1/1234", rvalid, rdata);
    end
    tick();
    total++;
    if (rvalid !== 1'b0 || rdata !== 16'h1234) begin
      bad++; $display("FAIL ram_idle: rvalid=%b rdata=%h want 0/1234", rvalid, rdata);
    end
    wr(9'd3, 16'h5A5A);
    rd(9'd3);
    total++;
    if (rdata !== 16'h5A5A) begin
      bad++; $display("FAIL ram_led_gap: rdata=%h want 5a5a", rdata);
    end
    wr(9'd511, 16'hBEEF);
    wr(9'd6, 16'h0F0F);
    rd(9'd511);
    total++;
    if (rdata !== 16'hBEEF) begin
      bad++; $display("FAIL ram_top: rdata=%h want beef", rdata);
    end
    rd(9'd6);
    total++;
    if (rdata !== 16'h0F0F) begin
      bad++; $display("FAIL ram_sw_gap: rdata=%h want 0f0f", rdata);
    end
    rd(9'd100);
    total++;
    if (rdata !== 16'h1234) begin
      bad++; $display("FAIL ram_keep: rdata=%h want 1234", rdata);
    end
  endtask

  task automatic test_led();
    wr(9'd0, 16'h0001);
    wr(9'd1, 16'h0000);
    total++;
    if (led_out !== 2'b01) begin
      bad++; $display("FAIL led_set: led_out=%b want 01", led_out);
    end
    rd(9'd0);
    total++;
    if (rdata !== 16'h0001) begin
      bad++; $display("FAIL led_rd0: rdata=%h want 0001", rdata);
    end
    wr(9'd0, 16'hFFFE);
    total++;
    if (led_out !== 2'b00) begin
      bad++; $display("FAIL led_bit0: led_out=%b want 00", led_out);
    end
    rd(9'd0);
    total++;
    if (rdata !== 16'hFFFE) begin
      bad++; $display("FAIL led_full: rdata=%h want fffe", rdata);
    end
    wr(9'd1, 16'h8001);
    rd(9'd1);
    total++;
    if (led_out !== 2'b10 || rdata !== 16'h8001) begin
      bad++; $display("FAIL led1: led_out=%b rdata=%h want 10/8001", led_out, rdata);
    end
  endtask

  task automatic test_sw();
    sw_in = 2'b10;
    repeat (SW_WAIT) tick();
    rd(9'd5);
    total++;
    if (rdata !== 16'h0001) begin
      bad++; $display("FAIL sw1: rdata=%h want 0001", rdata);
    end
    rd(9'd4);
    total++;
    if (rdata !== 16'h0000) begin
      bad++; $display("FAIL sw0: rdata=%h want 0000", rdata);
    end
    wr(9'd5, 16'hFFFF);
    rd(9'd5);
    total++;
    if (rdata !== 16'h0001) begin
      bad++; $display("FAIL sw_wr_ignored: rdata=%h want 0001", rdata);
    end
  endtask

  task automatic test_edge();
    rd(9'd8);
    total++;
    if (rdata !== 16'h0002) begin
      bad++; $display("FAIL edge_sw1: rdata=%h want 0002", rdata);
    end
    wr(9'd8, 16'hFFFF);
    rd(9'd8);
    total++;
    if (rdata !== 16'h0000) begin
      bad++; $display("FAIL edge_clr_all: rdata=%h want 0000", rdata);
    end
    sw_in = 2'b11;
    repeat (SW_WAIT) tick();
    rd(9'd8);
    total++;
    if (rdata !== 16'h0001) begin
      bad++; $display("FAIL edge_sw0: rdata=%h want 0001", rdata);
    end
    wr(9'd8, 16'h0001);
    rd(9'd8);
    total++;
    if (rdata !== 16'h0000) begin
      bad++; $display("FAIL edge_w1c: rdata=%h want 0000", rdata);
    end
    sw_in = 2'b10;
    repeat (SW_WAIT + 2) tick();
    rd(9'd8);
    total++;
    if (rdata !== 16'h0000) begin
      bad++; $display("FAIL edge_fall: rdata=%h want 0000", rdata);
    end
    sw_in = 2'b11;
    repeat (RISE_WAIT) tick();
    wr(9'd8, 16'h0001);
    rd(9'd8);
    total++;
    if (rdata !== 16'h0001) begin
      bad++; $display("FAIL edge_set_wins: rdata=%h want 0001", rdata);
    end
    wr(9'd8, 16'h0001);
    rd(9'd8);
    total++;
    if (rdata !== 16'h0000) begin
      bad++; $display("FAIL edge_clr_after: rdata=%h want 0000", rdata);
    end
  endtask

`ifdef SW_DEBOUNCE_EN
  task automatic test_debounce();
    sw_in = 2'b00;
    repeat (12) tick();
    wr(9'd8, 16'hFFFF);
    sw_in[1] = 1'b1;
    repeat (3) tick();
    sw_in[1] = 1'b0;
    repeat (10) tick();
    rd(9'd5);
    total++;
    if (rdata !== 16'h0000) begin
      bad++; $display("FAIL deb_glitch_sw: rdata=%h want 0000", rdata);
    end
    rd(9'd8);
    total++;
    if (rdata !== 16'h0000) begin
      bad++; $display("FAIL deb_glitch_edge: rdata=%h want 0000", rdata);
    end
    sw_in[1] = 1'b1;
    repeat (6) tick();
    rd(9'd5);
    total++;
    if (rdata !== 16'h0001) begin
      bad++; $display("FAIL deb_stable_sw: rdata=%h want 0001", rdata);
    end
    rd(9'd8);
    total++;
    if (rdata !== 16'h0002) begin
      bad++; $display("FAIL deb_stable_edge: rdata=%h want 0002", rdata);
    end
  endtask
`endif

  task automatic test_reset_mid();
    wr(9'd0, 16'h0001);
    wr(9'd1, 16'h0001);
    rd(9'd100);
    total++;
    if (led_out !== 2'b11 || rdata !== 16'h1234) begin
      bad++; $display("FAIL pre_reset: led_out=%b rdata=%h want 11/1234", led_out, rdata);
    end
    req = 1'b1; we = 1'b0; addr = 9'd100;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (rdata !== 16'h0000 || rvalid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_rd: rdata=%h rvalid=%b want 0000/0", rdata, rvalid);
    end
    total++;
    if (led_out !== 2'b00) begin
      bad++; $display("FAIL mid_reset_led: led_out=%b want 00", led_out);
    end
    req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (rvalid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_no_vld: rvalid=%b want 0", rvalid);
    end
    rd(9'd100);
    total++;
    if (rvalid !== 1'b1 || rdata !== 16'h1234) begin
      bad++; $display("FAIL ram_after_reset: rvalid=%b rdata=%h want 1/1234", rvalid, rdata);
    end
    rd(9'd0);
    total++;
    if (rdata !== 16'h0000) begin
      bad++; $display("FAIL led_after_reset: rdata=%h want 0000", rdata);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_sw();
    test_edge();
`ifdef SW_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
